// File: rtl/lc3b_types.sv
// Shared LC-3b types for the memory path.
// Holds the word and byte-mask widths, the arbiter state and port enums
// (shared with debug/monitor logic), and the latched request payload.
package lc3b_types;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned WMASK_W = 2;

    typedef logic [WORD_W-1:0]  lc3b_word;
    typedef logic [WMASK_W-1:0] lc3b_mem_wmask;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        IDLE,
        SERVE_A,
        SERVE_B,
        DONE_A,
        DONE_B
    } arb_state_t;

    // Requesting port identity
    typedef enum logic {
        PORT_A,
        PORT_B
    } arb_port_t;

    // One downstream memory request as held toward memory
    typedef struct packed {
        logic          read;
        logic          write;
        lc3b_mem_wmask wmask;
        lc3b_word      address;
        lc3b_word      wdata;
    } mem_req_t;

    // Build a request from a port's inputs; a write beats a simultaneous read
    function automatic mem_req_t make_req(
        input logic          read,
        input logic          write,
        input lc3b_mem_wmask wmask,
        input lc3b_word      address,
        input lc3b_word      wdata
    );
        mem_req_t r;
        r.read    = read & ~write;
        r.write   = write;
        r.wmask   = wmask;
        r.address = address;
        r.wdata   = wdata;
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-port bundle used for both CPU-side ports and the downstream port.
// Signals:
//   read/write   request strobes, held by the requester until resp
//   wmask        byte mask
//   address      word address
//   wdata        write data
//   resp         one-cycle completion pulse from the responder
//   rdata        read data, valid while resp is high
// Modports: master drives the request, slave answers it.
interface mem_port_arbiter_if;
    import lc3b_types::*;

    logic          read;
    logic          write;
    lc3b_mem_wmask wmask;
    lc3b_word      address;
    lc3b_word      wdata;
    logic          resp;
    lc3b_word      rdata;

    modport master (
        output read,
        output write,
        output wmask,
        output address,
        output wdata,
        input  resp,
        input  rdata
    );

    modport slave (
        input  read,
        input  write,
        input  wmask,
        input  address,
        input  wdata,
        output resp,
        output rdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-to-one round-robin memory arbiter.
// Merges the instruction-fetch port (A) and the data port (B) onto one
// downstream memory interface, one transaction at a time. The winning request
// is latched and driven toward memory from registers; the single-cycle memory
// response is registered and returned to the requesting port only.
// Ports:
//   clk     system clock, rising edge
//   rst_n   synchronous active-low reset
//   port_a  CPU port A (instruction fetch), slave side
//   port_b  CPU port B (data access), slave side
//   mem     downstream memory / cache, master side
module mem_port_arbiter
    import lc3b_types::*;
(
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  port_a,
    mem_port_arbiter_if.slave  port_b,
    mem_port_arbiter_if.master mem
);

    arb_state_t state;
    arb_port_t  last_grant;
    mem_req_t   req_q;
    lc3b_word   rdata_reg;
    logic       resp_a_q;
    logic       resp_b_q;

    logic       req_a_c;
    logic       req_b_c;
    logic       grant_b_c;
    mem_req_t   cand_c;

    // Grant decision: a lone requester wins; on a tie the port not served last wins
    always_comb begin
        req_a_c   = port_a.read | port_a.write;
        req_b_c   = port_b.read | port_b.write;
        grant_b_c = req_b_c & (~req_a_c | (last_grant == PORT_A));
        if (grant_b_c) begin
            cand_c = make_req(port_b.read, port_b.write, port_b.wmask,
                              port_b.address, port_b.wdata);
        end else begin
            cand_c = make_req(port_a.read, port_a.write, port_a.wmask,
                              port_a.address, port_a.wdata);
        end
    end

    // Arbiter FSM; every output toward memory and the ports comes from a register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= PORT_A;
            req_q      <= '0;
            rdata_reg  <= '0;
            resp_a_q   <= 1'b0;
            resp_b_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_a_q <= 1'b0;
                    resp_b_q <= 1'b0;
                    if (req_a_c | req_b_c) begin
                        req_q <= cand_c;
                        state <= grant_b_c ? SERVE_B : SERVE_A;
                    end
                end
                SERVE_A, SERVE_B: begin
                    // Live port inputs are not tracked here; only req_q matters
                    if (mem.resp) begin
                        rdata_reg   <= mem.rdata;
                        req_q.read  <= 1'b0;
                        req_q.write <= 1'b0;
                        if (state == SERVE_A) begin
                            last_grant <= PORT_A;
                            resp_a_q   <= 1'b1;
                            state      <= DONE_A;
                        end else begin
                            last_grant <= PORT_B;
                            resp_b_q   <= 1'b1;
                            state      <= DONE_B;
                        end
                    end
                end
                DONE_A, DONE_B: begin
                    // No grant here: the requester updates its inputs at this edge
                    resp_a_q <= 1'b0;
                    resp_b_q <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    resp_a_q    <= 1'b0;
                    resp_b_q    <= 1'b0;
                    req_q.read  <= 1'b0;
                    req_q.write <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign mem.read     = req_q.read;
    assign mem.write    = req_q.write;
    assign mem.wmask    = req_q.wmask;
    assign mem.address  = req_q.address;
    assign mem.wdata    = req_q.wdata;

    // Both ports see the captured data; it is only meaningful with that port's resp
    assign port_a.resp  = resp_a_q;
    assign port_a.rdata = rdata_reg;
    assign port_b.resp  = resp_b_q;
    assign port_b.rdata = rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import lc3b_types::*;

    typedef struct {
        logic          rd;
        logic          wr;
        lc3b_mem_wmask wm;
        lc3b_word      addr;
        lc3b_word      wd;
    } preq_t;

    typedef struct {
        int       port;
        logic     wr;
        lc3b_word addr;
    } txn_t;

    typedef struct {
        logic  has_a;
        preq_t a;
        logic  has_b;
        preq_t b;
        int    wait_cyc;
        int    exp_n;
        int    exp_first;
        logic  exp_first_wr;
    } vec_t;

    localparam int NONE = 2;   // port ids: 0 = A, 1 = B

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if port_a_bus();
    mem_port_arbiter_if port_b_bus();
    mem_port_arbiter_if mem_bus();

    mem_port_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .port_a (port_a_bus),
        .port_b (port_b_bus),
        .mem    (mem_bus)
    );

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    preq_t  qa[$];
    preq_t  qb[$];
    preq_t  cur_a;
    preq_t  cur_b;
    logic   act_a = 1'b0;
    logic   act_b = 1'b0;
    int     inflight = NONE;
    int     model_last = 0;
    preq_t  exp_req;
    logic   mem_act_prev = 1'b0;
    int     mem_wait = 0;
    logic   rand_wait = 1'b0;
    logic   mem_auto = 1'b1;
    logic   scribble = 1'b0;
    int     wcfg = 0;
    int     wcnt = 0;
    int     grant_log[$];
    txn_t   txn_log[$];
    int     resp_cnt_a = 0;
    int     resp_cnt_b = 0;
    int     resp_cyc_a[$];
    int     issue_log_a[$];
    lc3b_word last_rdata_a = '0;
    vec_t   vecs[6];

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic preq_t mk(input logic rd, input logic wr, input lc3b_mem_wmask wm,
                                 input lc3b_word addr, input lc3b_word wd);
        preq_t p;
        p.rd = rd; p.wr = wr; p.wm = wm; p.addr = addr; p.wd = wd;
        return p;
    endfunction

    // Memory contents as seen by reads: a fixed scramble of the address
    function automatic lc3b_word rd_data(input lc3b_word a);
        return a ^ 16'h2234;
    endfunction

    // What memory must see for a port request: a write wins over a read
    function automatic logic [35:0] req_bits(input preq_t p);
        return {p.rd & ~p.wr, p.wr, p.wm, p.addr, p.wd};
    endfunction

    function automatic logic [35:0] mem_bits();
        return {mem_bus.read, mem_bus.write, mem_bus.wmask, mem_bus.address, mem_bus.wdata};
    endfunction

    function automatic logic is_idle();
        return (qa.size() == 0) && (qb.size() == 0) && !act_a && !act_b && (inflight == NONE);
    endfunction

    task automatic drive_ports();
        port_a_bus.read    = act_a & cur_a.rd;
        port_a_bus.write   = act_a & cur_a.wr;
        port_a_bus.wmask   = act_a ? cur_a.wm : 2'b00;
        port_a_bus.address = act_a ? cur_a.addr : 16'h0000;
        port_a_bus.wdata   = act_a ? cur_a.wd : 16'h0000;
        port_b_bus.read    = act_b & cur_b.rd;
        port_b_bus.write   = act_b & cur_b.wr;
        port_b_bus.wmask   = act_b ? cur_b.wm : 2'b00;
        port_b_bus.address = act_b ? cur_b.addr : 16'h0000;
        port_b_bus.wdata   = act_b ? cur_b.wd : 16'h0000;
        // The granted port's payload may wander while served; memory must not follow
        if (scribble && inflight == 0) begin
            port_a_bus.wmask   = 2'($urandom);
            port_a_bus.address = 16'($urandom);
            port_a_bus.wdata   = 16'($urandom);
        end
        if (scribble && inflight == 1) begin
            port_b_bus.wmask   = 2'($urandom);
            port_b_bus.address = 16'($urandom);
            port_b_bus.wdata   = 16'($urandom);
        end
    endtask

    // One clock: observe, score against the model, run memory, then drive ports
    task automatic step();
        logic mr_prev;
        logic mem_act;
        logic exp_ra;
        logic exp_rb;
        int   port;
        mr_prev = mem_bus.resp;
        @(posedge clk);
        #1;
        cyc++;
        mem_act = mem_bus.read | mem_bus.write;
        if (!rst_n) begin
            inflight     = NONE;
            model_last   = 0;
            wcnt         = 0;
            mem_act_prev = 1'b0;
            if (mem_auto) mem_bus.resp = 1'b0;
        end else begin
            chk_eq("mem_op_exclusive", 64'(mem_bus.read & mem_bus.write), 64'd0);
            if (mem_act && !mem_act_prev) begin
                chk_eq("no_overlap", 64'(inflight), 64'(NONE));
                if (act_a && act_b) port = (model_last == 0) ? 1 : 0;
                else if (act_a)     port = 0;
                else if (act_b)     port = 1;
                else                port = NONE;
                chk_eq("grant_has_requester", 64'(port != NONE), 64'd1);
                if (port != NONE) begin
                    exp_req    = (port == 1) ? cur_b : cur_a;
                    inflight   = port;
                    model_last = port;
                    grant_log.push_back(port);
                    txn_log.push_back('{port, exp_req.wr, exp_req.addr});
                    wcfg = rand_wait ? int'($urandom_range(0, 3)) : mem_wait;
                    wcnt = 0;
                end
            end
            if (mem_act && inflight != NONE)
                chk_eq("mem_payload", 64'(mem_bits()), 64'(req_bits(exp_req)));
            exp_ra = mr_prev && (inflight == 0);
            exp_rb = mr_prev && (inflight == 1);
            chk_eq("resp_a", 64'(port_a_bus.resp), 64'(exp_ra));
            chk_eq("resp_b", 64'(port_b_bus.resp), 64'(exp_rb));
            if (exp_ra || exp_rb) begin
                chk_eq("mem_idle_in_done", 64'(mem_act), 64'd0);
                if (exp_req.rd && !exp_req.wr)
                    chk_eq("rdata", 64'(exp_ra ? port_a_bus.rdata : port_b_bus.rdata),
                           64'(rd_data(exp_req.addr)));
                if (exp_ra) begin
                    resp_cnt_a++;
                    resp_cyc_a.push_back(cyc);
                    last_rdata_a = port_a_bus.rdata;
                    act_a = 1'b0;
                end else begin
                    resp_cnt_b++;
                    act_b = 1'b0;
                end
                inflight = NONE;
            end
            if (mem_auto) begin
                if (mem_bus.resp) begin
                    mem_bus.resp  = 1'b0;
                    mem_bus.rdata = 16'($urandom);
                end else if (mem_act) begin
                    if (wcnt >= wcfg) begin
                        mem_bus.resp  = 1'b1;
                        mem_bus.rdata = rd_data(mem_bus.address);
                    end else begin
                        wcnt++;
                    end
                end else begin
                    mem_bus.rdata = 16'($urandom);
                end
            end
            mem_act_prev = mem_act;
        end
        if (!act_a && qa.size() > 0) begin
            cur_a = qa.pop_front();
            act_a = 1'b1;
            issue_log_a.push_back(cyc);
        end
        if (!act_b && qb.size() > 0) begin
            cur_b = qb.pop_front();
            act_b = 1'b1;
        end
        drive_ports();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!is_idle() && n < budget) begin
            step();
            n++;
        end
        chk_eq(name, 64'(is_idle()), 64'd1);
    endtask

    task automatic do_reset();
        qa.delete();
        qb.delete();
        act_a = 1'b0;
        act_b = 1'b0;
        scribble = 1'b0;
        rand_wait = 1'b0;
        mem_auto = 1'b1;
        mem_bus.resp = 1'b0;
        drive_ports();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        grant_log.delete();
        txn_log.delete();
        resp_cyc_a.delete();
        issue_log_a.delete();
        resp_cnt_a = 0;
        resp_cnt_b = 0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed_a;
        int pushed_b;
        int k;
        logic [1:0] op;
        rst_n = 1'b0;
        cur_a = mk(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        cur_b = cur_a;
        exp_req = cur_a;
        mem_bus.rdata = 16'h0000;

        // Reset state
        do_reset();
        chk_eq("rst_mem_read",  64'(mem_bus.read),    64'd0);
        chk_eq("rst_mem_write", 64'(mem_bus.write),   64'd0);
        chk_eq("rst_resp_a",    64'(port_a_bus.resp), 64'd0);
        chk_eq("rst_resp_b",    64'(port_b_bus.resp), 64'd0);
        chk_eq("rst_mem_addr",  64'(mem_bus.address), 64'd0);
        chk_eq("rst_mem_wdata", 64'(mem_bus.wdata),   64'd0);
        chk_eq("rst_mem_wmask", 64'(mem_bus.wmask),   64'd0);
        chk_eq("rst_rdata_a",   64'(port_a_bus.rdata), 64'd0);
        chk_eq("rst_rdata_b",   64'(port_b_bus.rdata), 64'd0);

        // Single read on A, memory with two wait cycles
        mem_wait = 2;
        qa.push_back(mk(1'b1, 1'b0, 2'b11, 16'h3000, 16'h0000));
        step();
        chk_eq("a_read_not_early", 64'(mem_bus.read), 64'd0);
        step();
        chk_eq("a_read_latency", 64'({mem_bus.read, mem_bus.address}), 64'({1'b1, 16'h3000}));
        wait_idle(50, "a_read_done");
        chk_eq("a_read_resp_cnt", 64'(resp_cnt_a), 64'd1);
        chk_eq("a_read_resp_b_cnt", 64'(resp_cnt_b), 64'd0);
        chk_eq("a_read_rdata", 64'(last_rdata_a), 64'h1234);

        // Vector table; each applied from reset so a tie goes to B first
        vecs[0] = '{1'b1, mk(1'b0, 1'b1, 2'b11, 16'h0100, 16'hBEEF), 1'b0, mk(1'b0, 1'b0, 2'b00, 16'h0, 16'h0), 1, 1, 0, 1'b1};
        vecs[1] = '{1'b0, mk(1'b0, 1'b0, 2'b00, 16'h0, 16'h0), 1'b1, mk(1'b1, 1'b1, 2'b01, 16'h4001, 16'h00AB), 0, 1, 1, 1'b1};
        vecs[2] = '{1'b1, mk(1'b1, 1'b0, 2'b11, 16'h0010, 16'h0), 1'b1, mk(1'b1, 1'b0, 2'b11, 16'h0020, 16'h0), 1, 2, 1, 1'b0};
        vecs[3] = '{1'b1, mk(1'b0, 1'b1, 2'b10, 16'h7FFE, 16'h5A5A), 1'b1, mk(1'b1, 1'b0, 2'b11, 16'hFFFF, 16'h0), 3, 2, 1, 1'b0};
        vecs[4] = '{1'b1, mk(1'b1, 1'b1, 2'b01, 16'h1111, 16'h2222), 1'b1, mk(1'b0, 1'b1, 2'b10, 16'h3333, 16'h4444), 0, 2, 1, 1'b1};
        vecs[5] = '{1'b0, mk(1'b0, 1'b0, 2'b00, 16'h0, 16'h0), 1'b1, mk(1'b1, 1'b0, 2'b00, 16'h0000, 16'hFFFF), 2, 1, 1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            mem_wait = vecs[i].wait_cyc;
            if (vecs[i].has_a) qa.push_back(vecs[i].a);
            if (vecs[i].has_b) qb.push_back(vecs[i].b);
            wait_idle(200, $sformatf("vec%0d_done", i));
            chk_eq($sformatf("vec%0d_count", i), 64'(txn_log.size()), 64'(vecs[i].exp_n));
            if (txn_log.size() > 0) begin
                chk_eq($sformatf("vec%0d_first_port", i), 64'(txn_log[0].port), 64'(vecs[i].exp_first));
                chk_eq($sformatf("vec%0d_first_wr", i), 64'(txn_log[0].wr), 64'(vecs[i].exp_first_wr));
            end
            if (txn_log.size() == 2)
                chk_eq($sformatf("vec%0d_second_port", i), 64'(txn_log[1].port), 64'(1 - vecs[i].exp_first));
        end

        // Starvation: both ports request continuously for six transactions
        do_reset();
        mem_wait = 1;
        for (int i = 0; i < 3; i++) begin
            qa.push_back(mk(1'b1, 1'b0, 2'b11, 16'(16'h0A00 + i), 16'h0));
            qb.push_back(mk(1'b0, 1'b1, 2'b11, 16'(16'h0B00 + i), 16'(16'hC000 + i)));
        end
        wait_idle(200, "starve_done");
        chk_eq("starve_count", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            if (i < grant_log.size())
                chk_eq($sformatf("starve_grant%0d", i), 64'(grant_log[i]), 64'((i % 2 == 0) ? 1 : 0));

        // Zero-wait memory: back-to-back on A, three cycles per transaction
        do_reset();
        mem_wait = 0;
        for (int i = 0; i < 4; i++) qa.push_back(mk(1'b1, 1'b0, 2'b11, 16'(16'h2000 + i), 16'h0));
        wait_idle(100, "zw_done");
        chk_eq("zw_count", 64'(resp_cyc_a.size()), 64'd4);
        if (resp_cyc_a.size() == 4 && issue_log_a.size() > 0) begin
            chk_eq("zw_first_latency", 64'(resp_cyc_a[0] - issue_log_a[0]), 64'd2);
            for (int i = 1; i < 4; i++)
                chk_eq($sformatf("zw_interval%0d", i), 64'(resp_cyc_a[i] - resp_cyc_a[i-1]), 64'd3);
        end

        // Reset in the middle of SERVE_A, then a stale memory response
        do_reset();
        mem_auto = 1'b0;
        qa.push_back(mk(1'b1, 1'b0, 2'b11, 16'h5555, 16'h0));
        for (int i = 0; i < 10 && !mem_bus.read; i++) step();
        chk_eq("rst_mid_reached_serve", 64'(mem_bus.read), 64'd1);
        step();
        rst_n = 1'b0;
        qa.delete();
        act_a = 1'b0;
        drive_ports();
        step();
        rst_n = 1'b1;
        chk_eq("rst_mid_mem_read", 64'(mem_bus.read), 64'd0);
        chk_eq("rst_mid_resp_a", 64'(port_a_bus.resp), 64'd0);
        mem_bus.resp  = 1'b1;
        mem_bus.rdata = 16'hDEAD;
        step();
        mem_bus.resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_eq("rst_mid_quiet", 64'({mem_bus.read, mem_bus.write}), 64'd0);
        end
        chk_eq("rst_mid_no_resp_a", 64'(resp_cnt_a), 64'd0);
        mem_auto = 1'b1;
        mem_wait = 0;
        qa.push_back(mk(1'b1, 1'b0, 2'b11, 16'h0123, 16'h0));
        step();
        step();
        chk_eq("rst_recover_latency", 64'({mem_bus.read, mem_bus.address}), 64'({1'b1, 16'h0123}));
        wait_idle(50, "rst_recover_done");
        chk_eq("rst_recover_resp", 64'(resp_cnt_a), 64'd1);

        // Randomized traffic with random memory latency and wandering payloads
        do_reset();
        rand_wait = 1'b1;
        scribble = 1'b1;
        pushed_a = 0;
        pushed_b = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && qa.size() < 2) begin
                k = int'($urandom_range(1, 3));
                op = 2'(k);
                qa.push_back(mk(op[0], op[1], 2'($urandom), 16'($urandom), 16'($urandom)));
                pushed_a++;
            end
            if ($urandom_range(0, 3) == 0 && qb.size() < 2) begin
                k = int'($urandom_range(1, 3));
                op = 2'(k);
                qb.push_back(mk(op[0], op[1], 2'($urandom), 16'($urandom), 16'($urandom)));
                pushed_b++;
            end
            step();
        end
        wait_idle(3000, "rand_drain");
        chk_eq("rand_total_a", 64'(resp_cnt_a), 64'(pushed_a));
        chk_eq("rand_total_b", 64'(resp_cnt_b), 64'(pushed_b));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
